// File: rtl/sequence_memory.sv
// Four-entry sequence store with a one-hot LED playback engine and a
// combinational read port for the downstream compare stage.
module sequence_memory #(
  parameter int DATA_W     = 8,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_MEM,
  input  logic              en_MEM,
  input  logic              MEM_LOAD,
  input  logic [1:0]        MEM_LOAD_VAL,
  input  logic [DATA_W-1:0] MEM_IN,
  input  logic              clr_MEM,
  input  logic              start_PLAY,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        mem_valid,
  output logic [3:0]        led_out,
  output logic              play_active,
  output logic              complete_PLAY
);

  localparam int NUM_ENT = 4;
  localparam int TMAX    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      idx, idx_nxt;
  logic [TW-1:0]                   timer, timer_nxt;
  logic [NUM_ENT-1:0][DATA_W-1:0]  mem;

  assign play_active   = (state == S_ON) || (state == S_OFF);
  assign complete_PLAY = (state == S_DONE);
  assign rd_data       = mem[rd_addr];
  assign led_out       = (state == S_ON) ? (4'b0001 << mem[idx][1:0]) : 4'b0000;

  // Data store ignores clr_MEM: a clear only drops the valid flags.
  always_ff @(posedge clk or posedge rst_MEM) begin
    if (rst_MEM) begin
      mem <= '0;
    end else if (MEM_LOAD && !play_active) begin
      for (int e = 0; e < NUM_ENT; e++)
        if (MEM_LOAD_VAL == 2'(e)) mem[e] <= MEM_IN;
    end
  end

  always_ff @(posedge clk or posedge rst_MEM) begin
    if (rst_MEM)
      mem_valid <= '0;
    else if (!play_active) begin
      if (clr_MEM)       mem_valid <= '0;
      else if (MEM_LOAD) mem_valid[MEM_LOAD_VAL] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_MEM) begin
    if (rst_MEM) begin
      state <= S_IDLE;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = '0;
    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        if (en_MEM && start_PLAY && (&mem_valid)) state_nxt = S_ON;
      end
      S_ON: begin
        if (!en_MEM) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else if (timer == ON_LAST) begin
          state_nxt = S_OFF;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_OFF: begin
        if (!en_MEM) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else if (timer == OFF_LAST) begin
          // idx 3 is the only way out to S_DONE; no wrap-around replay
          if (idx == 2'd3) state_nxt = S_DONE;
          else begin
            state_nxt = S_ON;
            idx_nxt   = idx + 2'd1;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequence_memory.sv
// Self-checking bench for sequence_memory: table-driven write/clear vectors
// plus scoreboarded LED playback sequences.
module tb_sequence_memory;

  localparam int DW  = 8;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int TOT = 4 * (ON + OFF) + 1;

  logic          clk = 1'b0;
  logic          rst_MEM, en_MEM, MEM_LOAD, clr_MEM, start_PLAY;
  logic [1:0]    MEM_LOAD_VAL, rd_addr;
  logic [DW-1:0] MEM_IN, rd_data;
  logic [3:0]    mem_valid, led_out;
  logic          play_active, complete_PLAY;

  sequence_memory #(.DATA_W(DW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk(clk), .rst_MEM(rst_MEM), .en_MEM(en_MEM), .MEM_LOAD(MEM_LOAD),
    .MEM_LOAD_VAL(MEM_LOAD_VAL), .MEM_IN(MEM_IN), .clr_MEM(clr_MEM),
    .start_PLAY(start_PLAY), .rd_addr(rd_addr), .rd_data(rd_data),
    .mem_valid(mem_valid), .led_out(led_out), .play_active(play_active),
    .complete_PLAY(complete_PLAY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ld;
    logic [1:0]    addr;
    logic [DW-1:0] data;
    logic          clr;
    logic [3:0]    exp_valid;
    logic [1:0]    rd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [3:0] led;
    logic       done;
    logic       act;
  } exp_t;

  vec_t          vecs[9];
  exp_t          sb[$];
  logic [DW-1:0] model_mem[4];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] led_map(input logic [DW-1:0] d);
    case (d[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      MEM_LOAD = vecs[i].ld; MEM_LOAD_VAL = vecs[i].addr; MEM_IN = vecs[i].data;
      clr_MEM = vecs[i].clr; rd_addr = vecs[i].rd;
      tick();
      MEM_LOAD = 1'b0; clr_MEM = 1'b0;
      if (vecs[i].ld) model_mem[vecs[i].addr] = vecs[i].data;
      chk($sformatf("vec%0d_valid", i), mem_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
    end
  endtask

  // Start a playback; abort_at>=0 drops en_MEM after that sample.
  task automatic run_play(input int abort_at, input bit wr_block, input bit hold_start);
    exp_t e;
    int   n = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < ON + OFF; c++) begin
        if (abort_at >= 0 && n > abort_at) e = '{4'b0000, 1'b0, 1'b0};
        else if (c < ON)                   e = '{led_map(model_mem[i]), 1'b0, 1'b1};
        else                               e = '{4'b0000, 1'b0, 1'b1};
        sb.push_back(e);
        n++;
      end
    end
    if (abort_at >= 0) sb.push_back('{4'b0000, 1'b0, 1'b0});
    else               sb.push_back('{4'b0000, 1'b1, 1'b0});

    en_MEM = 1'b1; start_PLAY = 1'b1;
    tick();
    if (!hold_start) start_PLAY = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("play_led_k%0d", k), led_out, e.led);
        chk($sformatf("play_done_k%0d", k), complete_PLAY, e.done);
        chk($sformatf("play_act_k%0d", k), play_active, e.act);
      end
      if (k == abort_at) en_MEM = 1'b0;
      if (wr_block && k == 5) begin
        MEM_LOAD = 1'b1; MEM_LOAD_VAL = 2'd1; MEM_IN = 8'h77; clr_MEM = 1'b1;
      end
      if (wr_block && k == 6) begin
        MEM_LOAD = 1'b0; clr_MEM = 1'b0;
      end
      tick();
    end
    chk("post_play_act", play_active, 1'b0);
    chk("post_play_done", complete_PLAY, 1'b0);
    if (hold_start) begin
      tick();
      chk("restart_act", play_active, 1'b1);
      chk("restart_led", led_out, led_map(model_mem[0]));
      start_PLAY = 1'b0; en_MEM = 1'b0;
      tick();
      chk("restart_abort_act", play_active, 1'b0);
    end
    en_MEM = 1'b1;
  endtask

  task automatic start_ignored(input string name);
    en_MEM = 1'b1; start_PLAY = 1'b1;
    tick();
    start_PLAY = 1'b0;
    chk({name, "_act"}, play_active, 1'b0);
    chk({name, "_led"}, led_out, 4'b0000);
    tick();
    chk({name, "_act2"}, play_active, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 8'hA5, 1'b0, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{1'b1, 2'd1, 8'h3C, 1'b0, 4'b0011, 2'd1, 8'h3C};
    vecs[2] = '{1'b1, 2'd2, 8'hFF, 1'b0, 4'b0111, 2'd2, 8'hFF};
    vecs[3] = '{1'b1, 2'd3, 8'h12, 1'b0, 4'b1111, 2'd3, 8'h12};
    vecs[4] = '{1'b1, 2'd2, 8'h55, 1'b1, 4'b0000, 2'd2, 8'h55};
    vecs[5] = '{1'b1, 2'd0, 8'h01, 1'b0, 4'b0001, 2'd0, 8'h01};
    vecs[6] = '{1'b1, 2'd1, 8'h02, 1'b0, 4'b0011, 2'd1, 8'h02};
    vecs[7] = '{1'b1, 2'd2, 8'h03, 1'b0, 4'b0111, 2'd2, 8'h03};
    vecs[8] = '{1'b1, 2'd3, 8'h00, 1'b0, 4'b1111, 2'd3, 8'h00};
    for (int i = 0; i < 4; i++) model_mem[i] = '0;

    rst_MEM = 1'b1; en_MEM = 1'b0; MEM_LOAD = 1'b0; clr_MEM = 1'b0;
    start_PLAY = 1'b0; MEM_LOAD_VAL = '0; MEM_IN = '0; rd_addr = '0;
    tick(); tick();
    rst_MEM = 1'b0;
    tick();
    chk("rst_valid", mem_valid, 4'b0000);
    chk("rst_led", led_out, 4'b0000);
    chk("rst_act", play_active, 1'b0);
    chk("rst_done", complete_PLAY, 1'b0);

    run_vec(0, 2);
    start_ignored("incomplete");
    run_vec(3, 3);

    run_play(-1, 1'b1, 1'b0);
    rd_addr = 2'd1;
    #1;
    chk("blocked_wr_rd", rd_data, 8'h3C);
    chk("blocked_wr_valid", mem_valid, 4'b1111);

    MEM_LOAD = 1'b1; MEM_LOAD_VAL = 2'd1; MEM_IN = 8'h77;
    tick();
    MEM_LOAD = 1'b0;
    model_mem[1] = 8'h77;
    chk("post_done_wr_rd", rd_data, 8'h77);

    run_play(7, 1'b0, 1'b0);
    run_play(-1, 1'b0, 1'b1);

    run_vec(4, 4);
    start_ignored("after_clear");

    run_vec(5, 8);
    en_MEM = 1'b1; start_PLAY = 1'b1;
    tick();
    start_PLAY = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_act", play_active, 1'b1);
    #2 rst_MEM = 1'b1;
    #1;
    chk("async_rst_valid", mem_valid, 4'b0000);
    chk("async_rst_led", led_out, 4'b0000);
    chk("async_rst_act", play_active, 1'b0);
    chk("async_rst_done", complete_PLAY, 1'b0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #0.1;
      chk($sformatf("async_rst_rd%0d", a), rd_data, 8'h00);
    end
    #1 rst_MEM = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      tick();
      chk($sformatf("post_rst_done_k%0d", k), complete_PLAY, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
